// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator with registered counters, syncs, DE and line/frame markers
module vga_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CNT_W      = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             de_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             line_o,
  output logic             frame_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             de_q, de_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             hs_act, vs_act;

  // Next raster position, and the markers decoded from that position so they
  // land in the same register stage as the counters (zero skew).
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en_i) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
    hs_act  = (x_d >= H_SS) && (x_d < H_SE);
    vs_act  = (y_d >= V_SS) && (y_d < V_SE);
    de_d    = (x_d < H_ACT) && (y_d < V_ACT);
    hsync_d = H_SYNC_POL ? hs_act : ~hs_act;
    vsync_d = V_SYNC_POL ? vs_act : ~vs_act;
    line_d  = (x_d == '0);
    frame_d = (x_d == '0) && (y_d == '0);
  end

  // State registers; reset parks the raster on its last position so the
  // first tick lands on (0,0).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      de_q    <= 1'b0;
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else if (en_i) begin
      x_q     <= x_d;
      y_q     <= y_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign de_o    = de_q;
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
  assign line_o  = line_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed table-driven bench for vga_timing (default and small raster)
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, en_a = 1'b0;
  logic       rst_b = 1'b0, en_b = 1'b0;
  logic [9:0] xa, ya, xb, yb;
  logic       dea, hsa, vsa, la, fa;
  logic       deb, hsb, vsb, lb, fb;

  vga_timing u_def (
    .clk_i(clk), .rst_i(rst_a), .en_i(en_a),
    .x_o(xa), .y_o(ya), .de_o(dea), .hsync_o(hsa), .vsync_o(vsa),
    .line_o(la), .frame_o(fa)
  );

  vga_timing #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(10)
  ) u_small (
    .clk_i(clk), .rst_i(rst_b), .en_i(en_b),
    .x_o(xb), .y_o(yb), .de_o(deb), .hsync_o(hsb), .vsync_o(vsb),
    .line_o(lb), .frame_o(fb)
  );

  int total = 0;
  int bad   = 0;
  int ax = 799, ay = 524;
  int bx = 7, by = 5;

  typedef struct {
    logic        en;
    logic [24:0] exp;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [24:0] pk(int x, int y, logic de, logic hs, logic vs, logic l, logic f);
    return {10'(x), 10'(y), de, hs, vs, l, f};
  endfunction

  function automatic logic [24:0] exp_def(int x, int y);
    return pk(x, y, (x < 640) && (y < 480), !((x >= 656) && (x < 752)),
              !((y >= 490) && (y < 492)), x == 0, (x == 0) && (y == 0));
  endfunction

  function automatic logic [24:0] exp_small(int x, int y);
    return pk(x, y, (x < 4) && (y < 3), (x >= 5) && (x < 7), y == 4, x == 0, (x == 0) && (y == 0));
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual={x=%0d y=%0d de,hs,vs,line,frame=%b} required={x=%0d y=%0d de,hs,vs,line,frame=%b}",
               name, act[24:15], act[14:5], act[4:0], exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step_a(input logic en, input string name);
    en_a = en;
    @(posedge clk);
    #1;
    if (en) begin
      if (ax == 799) begin
        ax = 0;
        ay = (ay == 524) ? 0 : ay + 1;
      end else begin
        ax++;
      end
    end
    check(name, {xa, ya, dea, hsa, vsa, la, fa}, exp_def(ax, ay));
  endtask

  task automatic step_b(input logic en, input string name);
    en_b = en;
    @(posedge clk);
    #1;
    if (en) begin
      if (bx == 7) begin
        bx = 0;
        by = (by == 5) ? 0 : by + 1;
      end else begin
        bx++;
      end
    end
    check(name, {xb, yb, deb, hsb, vsb, lb, fb}, exp_small(bx, by));
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, hs_last, line_at, r1, r2, vs_cnt, fr1, fr2, vs_x, vs_y, wrap_y, max_x;
    logic prev_l, prev_v, prev_f;
    int prev_y;

    tbl[0] = '{1'b1, pk(0, 0, 1, 0, 0, 1, 1)};
    tbl[1] = '{1'b1, pk(1, 0, 1, 0, 0, 0, 0)};
    tbl[2] = '{1'b0, pk(1, 0, 1, 0, 0, 0, 0)};
    tbl[3] = '{1'b1, pk(2, 0, 1, 0, 0, 0, 0)};
    tbl[4] = '{1'b1, pk(3, 0, 1, 0, 0, 0, 0)};
    tbl[5] = '{1'b1, pk(4, 0, 0, 0, 0, 0, 0)};
    tbl[6] = '{1'b1, pk(5, 0, 0, 1, 0, 0, 0)};
    tbl[7] = '{1'b1, pk(6, 0, 0, 1, 0, 0, 0)};
    tbl[8] = '{1'b1, pk(7, 0, 0, 0, 0, 0, 0)};
    tbl[9] = '{1'b1, pk(0, 1, 1, 0, 0, 1, 0)};

    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check("reset_def", {xa, ya, dea, hsa, vsa, la, fa}, pk(799, 524, 0, 1, 1, 0, 0));
    check("reset_small", {xb, yb, deb, hsb, vsb, lb, fb}, pk(7, 5, 0, 0, 0, 0, 0));
    rst_a = 1'b0;
    rst_b = 1'b0;

    // default raster: first tick and one full line
    step_a(1'b1, "def_first_model");
    check("def_first_tick", {xa, ya, dea, hsa, vsa, la, fa}, pk(0, 0, 1, 1, 1, 1, 1));
    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; line_at = -1;
    for (int i = 1; i <= 800; i++) begin
      step_a(1'b1, "def_line");
      if (dea) de_cnt++;
      if (!hsa) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(xa);
        hs_last = int'(xa);
      end
      if (la && line_at < 0) line_at = i;
    end
    check_int("de_per_line", de_cnt, 640);
    check_int("hsync_low_cnt", hs_cnt, 96);
    check_int("hsync_first_x", hs_first, 656);
    check_int("hsync_last_x", hs_last, 751);
    check_int("line_period", line_at, 800);

    // en_i on every second cycle: line period doubles
    r1 = -1; r2 = -1; prev_l = la;
    for (int i = 0; i < 3400; i++) begin
      step_a(i[0], "def_half_rate");
      if (la && !prev_l) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      prev_l = la;
    end
    check_int("line_period_half_rate", r2 - r1, 1600);

    // asynchronous reset in mid-line
    for (int i = 0; i < 800 && ax != 300; i++) step_a(1'b1, "def_seek");
    check_int("seek_x300", ax, 300);
    #2;
    rst_a = 1'b1;
    #1;
    check("async_reset_no_edge", {xa, ya, dea, hsa, vsa, la, fa}, pk(799, 524, 0, 1, 1, 0, 0));
    ax = 799;
    ay = 524;
    en_a = 1'b1;
    @(posedge clk);
    #1;
    check("reset_held", {xa, ya, dea, hsa, vsa, la, fa}, pk(799, 524, 0, 1, 1, 0, 0));
    rst_a = 1'b0;
    step_a(1'b1, "restart_model");
    check("restart_frame", {xa, ya, dea, hsa, vsa, la, fa}, pk(0, 0, 1, 1, 1, 1, 1));
    en_a = 1'b0;

    // small raster: hand vectors from reset
    for (int i = 0; i < 10; i++) begin
      step_b(tbl[i].en, "small_tbl_model");
      check($sformatf("small_tbl_%0d", i), {xb, yb, deb, hsb, vsb, lb, fb}, tbl[i].exp);
    end

    // small raster: two full frames
    de_cnt = 0; vs_cnt = 0; fr1 = -1; fr2 = -1; vs_x = -1; vs_y = -1; wrap_y = -1; max_x = 0;
    prev_v = vsb; prev_f = fb; prev_y = int'(yb);
    for (int i = 0; i < 96; i++) begin
      step_b(1'b1, "small_frame");
      if (deb) de_cnt++;
      if (vsb) vs_cnt++;
      if (vsb && !prev_v && vs_x < 0) begin
        vs_x = int'(xb);
        vs_y = int'(yb);
      end
      if (fb && !prev_f) begin
        if (fr1 < 0) fr1 = i;
        else if (fr2 < 0) fr2 = i;
      end
      if (prev_y == 5 && int'(yb) != 5 && wrap_y < 0) wrap_y = int'(yb);
      if (int'(xb) > max_x) max_x = int'(xb);
      prev_v = vsb; prev_f = fb; prev_y = int'(yb);
    end
    check_int("small_de_2frames", de_cnt, 24);
    check_int("small_vs_2frames", vs_cnt, 16);
    check_int("small_vs_rise_x", vs_x, 0);
    check_int("small_vs_rise_y", vs_y, 4);
    check_int("small_frame_period", fr2 - fr1, 48);
    check_int("small_y_wrap", wrap_y, 0);
    check_int("small_max_x", max_x, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
